fp_mant_div: RTL and testbench



---
 rtl/fp_mant_div_pkg.sv | 26 ++
 rtl/fp_mant_div_if.sv | 32 +++
 rtl/fp_mant_div_step.sv | 25 ++
 rtl/fp_mant_div.sv | 97 +++++++++
 tb/tb_fp_mant_div.sv | 135 +++++++++++++
 5 files changed

// File: rtl/fp_mant_div_pkg.sv
// fp_mant_div_pkg: shared widths, FSM state type and constants for the
// iterative mantissa divider.
//   MANT_W  mantissa width including hidden bit
//   Q_W     quotient width (one integer bit + MANT_W fraction bits)
//   R_W     partial-remainder width
package fp_mant_div_pkg;

    localparam int unsigned MANT_W = 24;
    localparam int unsigned Q_W    = 25;
    localparam int unsigned R_W    = 26;
    localparam int unsigned CNT_W  = 5;

    // Iteration counter start value; the count runs down through zero,
    // so Q_W trial subtractions are performed in total.
    localparam logic [CNT_W-1:0] CntStart = CNT_W'(Q_W - 1);

    // Quotient reported on divide-by-zero.
    localparam logic [Q_W-1:0] QDivZero = {Q_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFin  = 2'd2
    } state_e;

endpackage

// File: rtl/fp_mant_div_if.sv
// fp_mant_div_if: request/result bundle of the mantissa divider.
//   start   request, accepted only while idle
//   a, b    dividend / divisor mantissas (normalized or zero)
//   busy    iterating
//   done    one-cycle result strobe
//   q       quotient, floor(a/b * 2^24)
//   sticky  final remainder nonzero
//   dz      divide by zero
// master drives the request, slave (the divider) returns the result.
interface fp_mant_div_if;
    import fp_mant_div_pkg::*;

    logic              start;
    logic [MANT_W-1:0] a;
    logic [MANT_W-1:0] b;
    logic              busy;
    logic              done;
    logic [Q_W-1:0]    q;
    logic              sticky;
    logic              dz;

    modport master (
        output start, a, b,
        input  busy, done, q, sticky, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, sticky, dz
    );

endinterface

// File: rtl/fp_mant_div_step.sv
// fp_mant_div_step: one restoring-division step (combinational).
//   r_i  current partial remainder
//   d_i  divisor mantissa
//   q_o  quotient bit produced by this step
//   r_o  next partial remainder, already shifted left by one
module fp_mant_div_step
    import fp_mant_div_pkg::*;
(
    input  logic [R_W-1:0]    r_i,
    input  logic [MANT_W-1:0] d_i,
    output logic              q_o,
    output logic [R_W-1:0]    r_o
);

    logic [R_W-1:0] trial;

    always_comb begin
        trial = r_i - {2'b00, d_i};
        // r_i < 2*d_i < 2^25, so bit 25 of the difference is a clean sign bit.
        q_o   = ~trial[R_W-1];
        // Dropping the MSB on the shift is safe: the kept remainder is < d_i.
        r_o   = q_o ? {trial[R_W-2:0], 1'b0} : {r_i[R_W-2:0], 1'b0};
    end

endmodule

// File: rtl/fp_mant_div.sv
// fp_mant_div: iterative restoring divider for 24-bit normalized mantissas.
// One trial subtraction per clock; a result is strobed on done 26 clocks
// after an accepted start (1 clock for a zero divisor).
//   CLK     clock, rising edge
//   RST     synchronous active-high reset
//   bus_io  request/result bundle (slave side)
module fp_mant_div
    import fp_mant_div_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    fp_mant_div_if.slave  bus_io
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [R_W-1:0]     r_q;
    logic [MANT_W-1:0]  d_q;
    logic [Q_W-1:0]     q_q;
    logic               busy_q;
    logic               done_q;
    logic               sticky_q;
    logic               dz_q;

    logic               step_q;
    logic [R_W-1:0]     step_r;

    fp_mant_div_step u_step (
        .r_i (r_q),
        .d_i (d_q),
        .q_o (step_q),
        .r_o (step_r)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            r_q      <= '0;
            d_q      <= '0;
            q_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        if (bus_io.b == '0) begin
                            q_q      <= QDivZero;
                            sticky_q <= 1'b0;
                            dz_q     <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= StFin;
                        end else begin
                            r_q      <= {2'b00, bus_io.a};
                            d_q      <= bus_io.b;
                            cnt_q    <= CntStart;
                            q_q      <= '0;
                            sticky_q <= 1'b0;
                            dz_q     <= 1'b0;
                            busy_q   <= 1'b1;
                            state_q  <= StRun;
                        end
                    end
                end
                StRun: begin
                    r_q <= step_r;
                    q_q <= {q_q[Q_W-2:0], step_q};
                    if (cnt_q == '0) begin
                        sticky_q <= (step_r != '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= StFin;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.busy   = busy_q;
    assign bus_io.done   = done_q;
    assign bus_io.q      = q_q;
    assign bus_io.sticky = sticky_q;
    assign bus_io.dz     = dz_q;

endmodule

// File: tb/tb_fp_mant_div.sv
// tb_fp_mant_div: directed self-checking bench for fp_mant_div.
module tb_fp_mant_div;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp_mant_div_if bus ();

    fp_mant_div dut (
        .CLK    (clk),
        .RST    (rst),
        .bus_io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait (bounded) for done; checks result and timing.
    // If mid_start is nonzero, a second start with junk operands is pulsed
    // while the divider is running and must be ignored.
    task automatic run_div(input string tag, input logic [23:0] a, input logic [23:0] b,
                           input logic [24:0] exp_q, input logic exp_sticky,
                           input logic exp_dz, input int exp_lat, input bit mid_start);
        int n;
        bit busy_seen;
        busy_seen = 1'b0;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        // Operands are only sampled on the accepting edge.
        bus.a     = 24'h123456;
        bus.b     = 24'h000000;
        n = 1;
        while (bus.done !== 1'b1 && n < 60) begin
            if (bus.busy === 1'b1) busy_seen = 1'b1;
            bus.start = (mid_start && n == 5);
            bus.b     = mid_start ? 24'hFFFFFF : 24'h000000;
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check_val({tag, " latency"}, n, exp_lat);
        check_val({tag, " q"}, {7'd0, bus.q}, {7'd0, exp_q});
        check_val({tag, " sticky"}, {31'd0, bus.sticky}, {31'd0, exp_sticky});
        check_val({tag, " dz"}, {31'd0, bus.dz}, {31'd0, exp_dz});
        check_val({tag, " busy_in_run"}, {31'd0, busy_seen}, {31'd0, (exp_lat > 1)});
        check_val({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check_val({tag, " done_width"}, {31'd0, bus.done}, 32'd0);
        @(negedge clk);
        check_val({tag, " q_hold"}, {7'd0, bus.q}, {7'd0, exp_q});
    endtask

    initial begin
        int n;
        bit done_seen;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check_val("reset busy", {31'd0, bus.busy}, 32'd0);
        check_val("reset done", {31'd0, bus.done}, 32'd0);
        check_val("reset q", {7'd0, bus.q}, 32'd0);
        check_val("reset sticky", {31'd0, bus.sticky}, 32'd0);
        check_val("reset dz", {31'd0, bus.dz}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_div("one",   24'h800000, 24'h800000, 25'h1000000, 1'b0, 1'b0, 26, 1'b0);
        run_div("1p5",   24'hC00000, 24'h800000, 25'h1800000, 1'b0, 1'b0, 26, 1'b0);
        run_div("2of3",  24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b1, 1'b0, 26, 1'b0);
        run_div("max",   24'hFFFFFF, 24'h800000, 25'h1FFFFFE, 1'b0, 1'b0, 26, 1'b0);
        run_div("zeroa", 24'h000000, 24'hC00000, 25'h0000000, 1'b0, 1'b0, 26, 1'b0);
        run_div("divz",  24'h800000, 24'h000000, 25'h1FFFFFF, 1'b0, 1'b1, 1,  1'b0);
        run_div("ignst", 24'h800000, 24'hC00000, 25'h0AAAAAA, 1'b1, 1'b0, 26, 1'b1);

        // Reset at the 10th RUN cycle aborts the operation.
        bus.start = 1'b1;
        bus.a     = 24'hC00000;
        bus.b     = 24'h800000;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check_val("abort busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort busy", {31'd0, bus.busy}, 32'd0);
        check_val("abort done", {31'd0, bus.done}, 32'd0);
        check_val("abort q", {7'd0, bus.q}, 32'd0);
        check_val("abort sticky", {31'd0, bus.sticky}, 32'd0);
        check_val("abort dz", {31'd0, bus.dz}, 32'd0);
        done_seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen = 1'b1;
        end
        check_val("abort no_done", {31'd0, done_seen}, 32'd0);

        // Reset wins over a simultaneous start.
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.b     = 24'h000000;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check_val("rst_vs_start done", {31'd0, bus.done}, 32'd0);
        check_val("rst_vs_start dz", {31'd0, bus.dz}, 32'd0);
        @(negedge clk);
        check_val("rst_vs_start idle", {31'd0, bus.busy | bus.done}, 32'd0);

        // Back-to-back operation after reset still works.
        run_div("post", 24'hC00000, 24'h800000, 25'h1800000, 1'b0, 1'b0, 26, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
